// File: rtl/lc3_core_mc.sv
// lc3_core_mc: multi-cycle LC-3 subset core with separate instruction and
// data memory ports. Each instruction walks FETCH -> DECODE -> EXEC -> (MEM)
// -> WB. TRAP x25 parks the core in HALT until reset.
//
// Handshake (both memory ports): the core raises *_req together with the
// address (and store data / we) and holds all of them stable until it sees
// *_ready high on a rising clock edge; that edge completes the transfer (read
// data is sampled in the same cycle) and the core drops *_req on the
// following cycle. A ready that arrives while req is low is ignored.
//
// Assumes NREG >= 8 and AW <= DW (addresses are taken from the low AW bits
// of register values). dbg_state mirrors the FSM state for checkers.
module lc3_core_mc #(
  parameter int          DW       = 16,
  parameter int          AW       = 16,
  parameter int          NREG     = 8,
  parameter logic [15:0] RESET_PC = 16'h3000
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic [15:0]   imem_rdata,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ready,
  input  logic [DW-1:0] dmem_rdata,
  output logic [AW-1:0] pc,
  output logic          n,
  output logic          z,
  output logic          p,
  output logic          retire,
  output logic          halted,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam int RIW = (NREG > 8) ? $clog2(NREG) : 3;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  state_t          state_q;
  logic [AW-1:0]   pc_q;
  logic [15:0]     ir_q;
  logic [DW-1:0]   regs_q [NREG];
  logic            n_q, z_q, p_q;
  logic [DW-1:0]   opa_q, opb_q, src_q, imm_q, alu_q, mdr_q;
  logic [AW-1:0]   ea_q;
  logic            take_q;
  logic            imem_req_q;
  logic            dmem_req_q, dmem_we_q;
  logic [AW-1:0]   dmem_addr_q;
  logic [DW-1:0]   dmem_wdata_q;
  logic            retire_q, halted_q;

  // Decode / execute / write-back values derived from the current IR.
  logic [3:0]      op;
  logic [DW-1:0]   sr1_val, sr2_val, dr_val;
  logic [DW-1:0]   imm5_x, off6_x, off9_x;
  logic [DW-1:0]   alu_d, wb_val_d;
  logic [AW-1:0]   ea_d;
  logic            take_d, is_mem_d, is_store_d, wb_en_d, flag_en_d, is_halt_d;

  assign op        = ir_q[15:12];
  assign sr1_val   = regs_q[RIW'(ir_q[8:6])];
  assign sr2_val   = regs_q[RIW'(ir_q[2:0])];
  assign dr_val    = regs_q[RIW'(ir_q[11:9])];
  assign imm5_x    = {{(DW-5){ir_q[4]}}, ir_q[4:0]};
  assign off6_x    = {{(DW-6){ir_q[5]}}, ir_q[5:0]};
  assign off9_x    = {{(DW-9){ir_q[8]}}, ir_q[8:0]};

  // Combinational ALU, effective address, branch decision and WB selection.
  always_comb begin
    alu_d      = '0;
    ea_d       = pc_q + imm_q[AW-1:0];
    take_d     = 1'b0;
    is_mem_d   = 1'b0;
    is_store_d = 1'b0;
    wb_en_d    = 1'b0;
    flag_en_d  = 1'b0;
    wb_val_d   = alu_q;
    is_halt_d  = (op == OP_TRAP) && (ir_q[7:0] == 8'h25);
    case (op)
      OP_ADD: begin
        alu_d     = opa_q + opb_q;
        wb_en_d   = 1'b1;
        flag_en_d = 1'b1;
      end
      OP_AND: begin
        alu_d     = opa_q & opb_q;
        wb_en_d   = 1'b1;
        flag_en_d = 1'b1;
      end
      OP_NOT: begin
        alu_d     = ~opa_q;
        wb_en_d   = 1'b1;
        flag_en_d = 1'b1;
      end
      OP_BR: begin
        take_d = |(ir_q[11:9] & {n_q, z_q, p_q});
      end
      OP_JMP: begin
        ea_d   = opa_q[AW-1:0];
        take_d = 1'b1;
      end
      OP_LD: begin
        is_mem_d  = 1'b1;
        wb_en_d   = 1'b1;
        flag_en_d = 1'b1;
        wb_val_d  = mdr_q;
      end
      OP_LDR: begin
        ea_d      = opa_q[AW-1:0] + imm_q[AW-1:0];
        is_mem_d  = 1'b1;
        wb_en_d   = 1'b1;
        flag_en_d = 1'b1;
        wb_val_d  = mdr_q;
      end
      OP_ST: begin
        is_mem_d   = 1'b1;
        is_store_d = 1'b1;
      end
      OP_STR: begin
        ea_d       = opa_q[AW-1:0] + imm_q[AW-1:0];
        is_mem_d   = 1'b1;
        is_store_d = 1'b1;
      end
      OP_LEA: begin
        wb_en_d  = 1'b1;
        wb_val_d = DW'(ea_q);
      end
      default: begin
        alu_d = '0;
      end
    endcase
  end

  // Main FSM: sequences the instruction phases and owns all architectural state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= AW'(RESET_PC);
      ir_q         <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      n_q          <= 1'b0;
      z_q          <= 1'b1;
      p_q          <= 1'b0;
      opa_q        <= '0;
      opb_q        <= '0;
      src_q        <= '0;
      imm_q        <= '0;
      alu_q        <= '0;
      mdr_q        <= '0;
      ea_q         <= '0;
      take_q       <= 1'b0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      retire_q     <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          // Coming out of reset the request is still low; raise it first.
          if (!imem_req_q) begin
            imem_req_q <= 1'b1;
          end else if (imem_ready) begin
            ir_q       <= imem_rdata;
            pc_q       <= pc_q + AW'(1);
            imem_req_q <= 1'b0;
            state_q    <= S_DECODE;
          end
        end
        S_DECODE: begin
          opa_q   <= sr1_val;
          opb_q   <= ir_q[5] ? imm5_x : sr2_val;
          src_q   <= dr_val;
          imm_q   <= ((op == OP_LDR) || (op == OP_STR)) ? off6_x : off9_x;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          alu_q  <= alu_d;
          ea_q   <= ea_d;
          take_q <= take_d;
          if (is_mem_d) begin
            dmem_req_q  <= 1'b1;
            dmem_we_q   <= is_store_d;
            dmem_addr_q <= ea_d;
            if (is_store_d) dmem_wdata_q <= src_q;
            state_q     <= S_MEM;
          end else begin
            retire_q <= 1'b1;
            state_q  <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_req_q && dmem_ready) begin
            mdr_q      <= dmem_rdata;
            dmem_req_q <= 1'b0;
            retire_q   <= 1'b1;
            state_q    <= S_WB;
          end
        end
        S_WB: begin
          if (wb_en_d) regs_q[RIW'(ir_q[11:9])] <= wb_val_d;
          if (flag_en_d) begin
            n_q <= wb_val_d[DW-1];
            z_q <= (wb_val_d == '0);
            p_q <= ~wb_val_d[DW-1] & (wb_val_d != '0);
          end
          if (take_q) pc_q <= ea_q;
          if (is_halt_d) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            imem_req_q <= 1'b1;
            state_q    <= S_FETCH;
          end
        end
        S_HALT: begin
          halted_q <= 1'b1;
        end
        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign pc         = pc_q;
  assign n          = n_q;
  assign z          = z_q;
  assign p          = p_q;
  assign retire     = retire_q;
  assign halted     = halted_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_lc3_core_mc.sv
// Directed bench for lc3_core_mc: a DW=16 core on wait-state memory models
// and a DW=32 core on a tiny zero-wait program ROM.
module tb_lc3_core_mc;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic rst32 = 1'b1;

  // ---------------- DW=16 instance ----------------
  logic        imem_req, imem_ready;
  logic [15:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [15:0] pc;
  logic        n, z, p, retire, halted;
  logic [2:0]  dbg_state;

  lc3_core_mc #(.DW(16), .AW(16), .NREG(8), .RESET_PC(16'h3000)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .pc(pc), .n(n), .z(z), .p(p), .retire(retire), .halted(halted), .dbg_state(dbg_state)
  );

  // ---------------- DW=32 instance ----------------
  logic        imem_req32, imem_ready32;
  logic [15:0] imem_addr32, imem_rdata32;
  logic        dmem_req32, dmem_we32;
  logic [15:0] dmem_addr32;
  logic [31:0] dmem_wdata32;
  logic        dmem_ready32 = 1'b0;
  logic [31:0] dmem_rdata32 = 32'h0;
  logic [15:0] pc32;
  logic        n32, z32, p32, retire32, halted32;
  logic [2:0]  dbg_state32;

  lc3_core_mc #(.DW(32), .AW(16), .NREG(8), .RESET_PC(16'h3000)) u_dut32 (
    .clk(clk), .rst(rst32),
    .imem_req(imem_req32), .imem_addr(imem_addr32), .imem_ready(imem_ready32), .imem_rdata(imem_rdata32),
    .dmem_req(dmem_req32), .dmem_we(dmem_we32), .dmem_addr(dmem_addr32), .dmem_wdata(dmem_wdata32),
    .dmem_ready(dmem_ready32), .dmem_rdata(dmem_rdata32),
    .pc(pc32), .n(n32), .z(z32), .p(p32), .retire(retire32), .halted(halted32), .dbg_state(dbg_state32)
  );

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          ret_q[$];
  logic [15:0] exp_q[$];          // expected fetch addresses, in order
  logic [15:0] exp_a;
  int          extra_fetch = 0;
  int          both_req = 0;
  int          st_cyc = 0;
  int          st_good = 0;

  logic [15:0] imem [0:65535];
  logic [15:0] dmem [0:65535];
  logic [15:0] prog32 [0:3];
  int          imem_wait = 0;
  int          dmem_wait = 0;
  int          icnt = 0;
  int          dcnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- memory models and monitors (negedge) ----------------
  always @(negedge clk) begin
    cyc++;
    if (retire) ret_q.push_back(cyc);
    if (imem_req && dmem_req) both_req++;
    if (dmem_req && dmem_we) begin
      st_cyc++;
      if (dmem_addr == 16'h3FFF && dmem_wdata == 16'h1234) st_good++;
    end
    // instruction memory
    if (imem_req) begin
      if (icnt >= imem_wait) begin
        imem_ready = 1'b1;
        imem_rdata = imem[imem_addr];
        if (exp_q.size() > 0) begin
          exp_a = exp_q.pop_front();
          chk("fetch_addr", 64'(imem_addr), 64'(exp_a));
        end else begin
          extra_fetch++;
        end
      end else begin
        imem_ready = 1'b0;
      end
      icnt++;
    end else begin
      imem_ready = 1'b0;
      icnt = 0;
    end
    // data memory
    if (dmem_req) begin
      if (dcnt >= dmem_wait) begin
        dmem_ready = 1'b1;
        if (dmem_we) dmem[dmem_addr] = dmem_wdata;
        else dmem_rdata = dmem[dmem_addr];
      end else begin
        dmem_ready = 1'b0;
      end
      dcnt++;
    end else begin
      dmem_ready = 1'b0;
      dcnt = 0;
    end
    // zero-wait ROM for the 32-bit core
    imem_ready32 = imem_req32;
    imem_rdata32 = prog32[imem_addr32[1:0]];
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) begin
      imem[i] = 16'h0000;
      dmem[i] = 16'h0000;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", 64'(pc), 64'h3000);
    chk("rst_nzp", 64'({n, z, p}), 64'b010);
    chk("rst_imem_req", 64'(imem_req), 64'd0);
    chk("rst_dmem_req", 64'({dmem_req, dmem_we}), 64'd0);
    chk("rst_dmem_bus", 64'({dmem_addr, dmem_wdata}), 64'd0);
    chk("rst_retire_halt", 64'({retire, halted}), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    chk("rst_r1", 64'(u_dut.regs_q[1]), 64'd0);
    ret_q.delete();
    extra_fetch = 0;
    st_cyc = 0;
    st_good = 0;
    rst = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget && !halted; i++) @(negedge clk);
    chk("halt_reached", 64'(halted), 64'd1);
  endtask

  task automatic wait_retire(input int budget);
    for (int i = 0; i < budget && !retire; i++) @(negedge clk);
    chk("retire_seen", 64'(retire), 64'd1);
  endtask

  task automatic check_fetches();
    chk("fetch_left", 64'(exp_q.size()), 64'd0);
    chk("fetch_extra", 64'(extra_fetch), 64'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int spacing;
    int stable;
    imem_ready = 1'b0;
    imem_rdata = 16'h0;
    dmem_ready = 1'b0;
    dmem_rdata = 16'h0;
    prog32[0] = 16'h123F;   // ADD R1,R0,#-1
    prog32[1] = 16'h947F;   // NOT R2,R1
    prog32[2] = 16'hF025;   // HALT
    prog32[3] = 16'h0000;

    // Test 1: ADD/ADD/HALT on zero-wait memory.
    clear_mem();
    imem[16'h3000] = 16'h1225;   // ADD R1,R0,#5
    imem[16'h3001] = 16'h1479;   // ADD R2,R1,#-7
    imem[16'h3002] = 16'hF025;   // HALT
    exp_q = '{16'h3000, 16'h3001, 16'h3002};
    do_reset();
    wait_halt(200);
    repeat (5) @(negedge clk);
    chk("t1_r1", 64'(u_dut.regs_q[1]), 64'h5);
    chk("t1_r2", 64'(u_dut.regs_q[2]), 64'hFFFE);
    chk("t1_nzp", 64'({n, z, p}), 64'b100);
    chk("t1_retires", 64'(ret_q.size()), 64'd3);
    chk("t1_pc", 64'(pc), 64'h3003);
    chk("t1_req_after_halt", 64'({imem_req, dmem_req}), 64'd0);
    spacing = (ret_q.size() >= 2) ? ret_q[1] - ret_q[0] : -1;
    chk("t1_ret_spacing", 64'(spacing), 64'd4);
    check_fetches();

    // Test 2: LD negative value, BRn taken over two ADDs.
    clear_mem();
    imem[16'h3000] = 16'h260F;   // LD R3, x3010
    imem[16'h3001] = 16'h0802;   // BRn +2
    imem[16'h3002] = 16'h1921;   // ADD R4,R4,#1 (skipped)
    imem[16'h3003] = 16'h1921;   // ADD R4,R4,#1 (skipped)
    imem[16'h3004] = 16'hF025;   // HALT
    dmem[16'h3010] = 16'h8000;
    exp_q = '{16'h3000, 16'h3001, 16'h3004};
    do_reset();
    wait_halt(200);
    chk("t2_r3", 64'(u_dut.regs_q[3]), 64'h8000);
    chk("t2_r4", 64'(u_dut.regs_q[4]), 64'h0);
    chk("t2_nzp", 64'({n, z, p}), 64'b100);
    chk("t2_retires", 64'(ret_q.size()), 64'd3);
    chk("t2_pc", 64'(pc), 64'h3005);
    check_fetches();

    // Test 3: STR R1,R6,#-1 with 3 data wait states.
    clear_mem();
    imem[16'h3000] = 16'h2C0F;   // LD R6, x3010
    imem[16'h3001] = 16'h220F;   // LD R1, x3011
    imem[16'h3002] = 16'h73BF;   // STR R1,R6,#-1
    imem[16'h3003] = 16'hF025;   // HALT
    dmem[16'h3010] = 16'h4000;
    dmem[16'h3011] = 16'h1234;
    dmem_wait = 3;
    exp_q = '{16'h3000, 16'h3001, 16'h3002, 16'h3003};
    do_reset();
    wait_halt(300);
    chk("t3_r6", 64'(u_dut.regs_q[6]), 64'h4000);
    chk("t3_mem", 64'(dmem[16'h3FFF]), 64'h1234);
    chk("t3_store_cycles", 64'(st_cyc), 64'd4);
    chk("t3_store_stable", 64'(st_good), 64'd4);
    spacing = (ret_q.size() >= 3) ? ret_q[2] - ret_q[1] : -1;
    chk("t3_str_latency", 64'(spacing), 64'd8);
    chk("t3_nzp", 64'({n, z, p}), 64'b001);
    check_fetches();
    dmem_wait = 0;

    // Test 4: fetch stalled 10 cycles after the first retire.
    clear_mem();
    imem[16'h3000] = 16'h1225;
    imem[16'h3001] = 16'h1479;
    imem[16'h3002] = 16'hF025;
    exp_q = '{16'h3000, 16'h3001, 16'h3002};
    do_reset();
    wait_retire(50);
    imem_wait = 10;
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 16'h3001 && !retire && !dmem_req &&
          u_dut.regs_q[1] == 16'h5 && u_dut.regs_q[2] == 16'h0 && {n, z, p} == 3'b001)
        stable++;
    end
    chk("t4_stall_stable", 64'(stable), 64'd10);
    @(negedge clk);
    imem_wait = 0;
    wait_halt(200);
    chk("t4_r2", 64'(u_dut.regs_q[2]), 64'hFFFE);
    chk("t4_retires", 64'(ret_q.size()), 64'd3);
    check_fetches();

    // Test 5: reset while an LD sits in MEM.
    clear_mem();
    imem[16'h3000] = 16'h260F;   // LD R3, x3010
    imem[16'h3001] = 16'hF025;   // HALT
    dmem[16'h3010] = 16'hBEEF;
    dmem_wait = 5;
    exp_q = '{16'h3000, 16'h3000, 16'h3001};
    do_reset();
    for (int i = 0; i < 50 && !dmem_req; i++) @(negedge clk);
    chk("t5_mem_reached", 64'(dmem_req), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_dmem_req_drop", 64'(dmem_req), 64'd0);
    chk("t5_pc", 64'(pc), 64'h3000);
    chk("t5_z", 64'({n, z, p}), 64'b010);
    chk("t5_r3_unwritten", 64'(u_dut.regs_q[3]), 64'h0);
    @(negedge clk);
    chk("t5_retire_none", 64'(ret_q.size()), 64'd0);
    rst = 1'b0;
    dmem_wait = 0;
    wait_halt(200);
    chk("t5_r3", 64'(u_dut.regs_q[3]), 64'hBEEF);
    chk("t5_retires", 64'(ret_q.size()), 64'd2);
    check_fetches();

    // Test 6: DW=32 core, ADD -1 then NOT.
    @(negedge clk);
    @(negedge clk);
    rst32 = 1'b0;
    for (int i = 0; i < 50 && !retire32; i++) @(negedge clk);
    chk("t6_retire_seen", 64'(retire32), 64'd1);
    @(negedge clk);
    chk("t6_r1", 64'(u_dut32.regs_q[1]), 64'hFFFF_FFFF);
    chk("t6_nzp1", 64'({n32, z32, p32}), 64'b100);
    for (int i = 0; i < 100 && !halted32; i++) @(negedge clk);
    chk("t6_halted", 64'(halted32), 64'd1);
    chk("t6_r2", 64'(u_dut32.regs_q[2]), 64'h0);
    chk("t6_nzp2", 64'({n32, z32, p32}), 64'b010);
    chk("t6_pc", 64'(pc32), 64'h3003);

    chk("req_overlap", 64'(both_req), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop if something wedges outside every bounded wait.
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got cycle %0d expected finish earlier", cyc);
    $fatal(1, "timeout");
  end

endmodule
